core_ex_muldiv_seq: RTL and testbench
=====================================

# core_ex_muldiv_seq

Parametrised multi-cycle M-extension execute unit for the EX stage: RV32M/RV64M multiply (pipelined, configurable depth) and iterative radix-2 divide/remainder behind a valid/ready handshake, with pipeline flush. It replaces the fixed-depth multiplier-only path. The EX stage uses its `ready_o`/`valid_o` to stall the pipeline while an operation is in flight. One operation is outstanding at a time.

## Interface
- `XLEN`, 32, operand/result width (32 or 64).
- `MUL_LATENCY`, 3, cycles from accept to `valid_o` for MUL*; legal range ≥1.
- `EARLY_OUT`, 1, 1 = divide-by-zero and signed-overflow complete in 2 cycles; 0 = full iteration.

Ports:
- `clk_i` in 1 clock; all state on rising edge.
- `rst_ni` in 1 reset; asynchronous, active-low.
- `valid_i` in 1 operation request.
- `ready_o` out 1 unit can accept; high only in IDLE.
- `op_i` in 3 funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_i`, `rs2_i` in XLEN operands (already forwarded).
- `rd_i` in 5 destination register tag.
- `flush_i` in 1 kill in-flight op.
- `valid_o` out 1 result available.
- `ready_i` in 1 consumer takes result.
- `result_o` out XLEN result.
- `rd_o` out 5 tag of result.
- `busy_o` out 1 state ≠ IDLE.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- Accept on `valid_i && ready_o && !flush_i`. Latch op, operands, `rd_i`, and go to MUL (op<4) or DIV.
- MUL: operands extended to XLEN+1 bits. rs1 is signed for ops 1,2. rs2 is signed for op 1 only. Take the 2·XLEN product. MUL returns the low XLEN bits; the others return the high XLEN bits. A down-counter loaded with MUL_LATENCY−1 moves to DONE at zero.
- DIV:
  - Cycle 1 (prep): take absolute values for signed ops and record the quotient/remainder signs. Detect divisor==0 and overflow (rs1 = most-negative, rs2 = −1, signed ops only).
  - Then XLEN shift-subtract iterations. Then 1 sign-fix cycle, then DONE.
- Special results, identical whether `EARLY_OUT` is 0 or 1:
  - Divisor 0: quotient = all-ones; remainder = rs1.
  - Overflow: quotient = rs1; remainder = 0.
- Sign rules: quotient is negative iff the operand signs differ (signed ops). Remainder takes the sign of the dividend.
- DONE: `valid_o`=1. `result_o`/`rd_o` are registered and stable while `valid_o && !ready_i`. Go to IDLE when `ready_i`.
- Flush from any state: go to IDLE on the next edge. `valid_o` drops that edge and the result is discarded. A `valid_i` in the same cycle is ignored.
- Reset: state IDLE. `valid_o`=0, `busy_o`=0, `ready_o`=1, `result_o`=0, `rd_o`=0, counters 0.

## Timing
- Accept at edge E0. `valid_o` rises after edge:
  - MUL: E(MUL_LATENCY).
  - DIV: E(XLEN+2) (33+1=34 for XLEN=32).
  - DIV special case with EARLY_OUT=1: E2.
- `ready_o` is low from E0 until the edge after the `valid_o && ready_i` handshake. There is no same-cycle back-to-back accept, so the minimum issue interval is latency+1.
- `ready_o` and `busy_o` are combinational from state. `valid_o`, `result_o` and `rd_o` are registered.
- Flush and `ready_i` high in DONE in the same cycle: flush wins. The result is not considered consumed.
- Async reset mid-operation: all outputs return to reset values immediately. No partial state survives.

## Structure
- Package `core_md_pkg`: `md_op_e` (funct3 enum), `md_state_e`, helper `md_is_div(op)`.
- Sub-module `md_div_iter`: holds remainder/quotient shift registers and the iteration counter, with start/done ports. The top level holds the FSM, the multiplier pipeline, sign handling and the output register.
- Target 200–350 lines in total.

## Test plan
- MUL 7 × 0xFFFFFFFD, no backpressure -> `valid_o` at E3, `result_o`=0xFFFFFFEB. MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at E34. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- DIV 5/0 -> 0xFFFFFFFF at E2 (EARLY_OUT=1) or E34 (EARLY_OUT=0). REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- Backpressure: hold `ready_i`=0 for 5 cycles in DONE -> `valid_o`, `result_o` and `rd_o` stable. `ready_o` rises one cycle after `ready_i`.
- Flush at DIV iteration 10 -> IDLE next cycle, no `valid_o`. The next MUL 3×4 returns 12 with correct `rd_o`.
- Assert `rst_ni` low mid-MUL -> outputs at reset values asynchronously. After release, `ready_o`=1 and a new op completes normally.

Source files
------------

// File: rtl/core_md_pkg.sv
// Shared types and helpers for the M-extension execute unit: funct3 encoding,
// FSM states and small opcode decode functions.
package core_md_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_e;

    // Sub-phase of ST_DIV: one prep cycle, then iteration until the iterator reports done.
    typedef enum logic {
        DS_PREP,
        DS_ITER
    } md_div_step_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic md_is_signed_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic md_is_rem(input md_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes: one quotient bit per
// cycle, XLEN cycles after start; done stays high until the next start or kill.
module md_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CNT_W = $clog2(XLEN + 1);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvs_q;

    logic [XLEN:0]    rem_sh;
    logic             sub_ok;
    logic [XLEN-1:0]  rem_sub;

    // Partial remainder is always below the divisor, so the low XLEN bits of the difference are exact.
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign sub_ok  = (rem_sh >= {1'b0, dvs_q});
    assign rem_sub = rem_sh[XLEN-1:0] - dvs_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
        end else if (kill_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= CNT_W'(XLEN);
            rem_q    <= '0;
            quo_q    <= dividend_i;
            dvs_q    <= divisor_i;
        end else if (active_q && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
            rem_q <= sub_ok ? rem_sub : rem_sh[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], sub_ok};
        end
    end

    assign done_o      = active_q && (cnt_q == '0);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/core_ex_muldiv_seq.sv
// EX-stage M-extension unit: multi-cycle multiply and iterative divide/remainder
// behind a valid/ready handshake, one operation in flight, flushable at any time.
module core_ex_muldiv_seq
    import core_md_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 3,
    parameter int EARLY_OUT   = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            busy_o
);

    localparam int MCNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cond_negate(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    md_state_e        state_q, state_d;
    md_div_step_e     step_q;
    md_op_e           op_q;
    logic [XLEN-1:0]  rs1_q, rs2_q;
    logic [4:0]       rd_q;
    logic [MCNT_W-1:0] mul_cnt_q;
    logic             div_zero_q, div_ovf_q, q_neg_q, r_neg_q;

    logic             accept, div_start, finish;
    logic [XLEN-1:0]  result_d;

    // Multiplier: sign-extend per opcode and keep the 2*XLEN-bit product.
    logic                   a_sgn, b_sgn;
    logic signed [2*XLEN-1:0] a_wide, b_wide, prod;
    logic [XLEN-1:0]        mul_res;

    assign a_sgn   = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    assign b_sgn   = (op_q == OP_MULH);
    assign a_wide  = {{XLEN{a_sgn & rs1_q[XLEN-1]}}, rs1_q};
    assign b_wide  = {{XLEN{b_sgn & rs2_q[XLEN-1]}}, rs2_q};
    assign prod    = a_wide * b_wide;
    assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Divider prep: magnitudes, result signs and the two special cases.
    logic            div_sgn, a_neg, b_neg, div_zero_d, div_ovf_d, special;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_done;
    logic [XLEN-1:0] quo_raw, rem_raw, div_res;

    assign div_sgn    = md_is_signed_div(op_q);
    assign a_neg      = div_sgn & rs1_q[XLEN-1];
    assign b_neg      = div_sgn & rs2_q[XLEN-1];
    assign a_abs      = cond_negate(a_neg, rs1_q);
    assign b_abs      = cond_negate(b_neg, rs2_q);
    assign div_zero_d = (rs2_q == '0);
    assign div_ovf_d  = div_sgn && (rs1_q == MOST_NEG) && (rs2_q == '1);
    assign special    = div_zero_q | div_ovf_q;

    md_div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (div_start),
        .kill_i      (flush_i),
        .dividend_i  (a_abs),
        .divisor_i   (b_abs),
        .done_o      (div_done),
        .quotient_o  (quo_raw),
        .remainder_o (rem_raw)
    );

    always_comb begin
        div_res = md_is_rem(op_q) ? cond_negate(r_neg_q, rem_raw) : cond_negate(q_neg_q, quo_raw);
        if (div_zero_q) begin
            div_res = md_is_rem(op_q) ? rs1_q : '1;
        end else if (div_ovf_q) begin
            div_res = md_is_rem(op_q) ? '0 : rs1_q;
        end
    end

    assign result_d = md_is_div(op_q) ? div_res : mul_res;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        div_start = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    accept  = 1'b1;
                    state_d = md_is_div(md_op_e'(op_i)) ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (step_q == DS_PREP) begin
                    div_start = 1'b1;
                end else if (((EARLY_OUT != 0) && special) || div_done) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides everything, including a same-cycle request or result consumption.
        if (flush_i) begin
            state_d   = ST_IDLE;
            accept    = 1'b0;
            div_start = 1'b0;
            finish    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= OP_MUL;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            mul_cnt_q  <= '0;
            step_q     <= DS_PREP;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            valid_o    <= 1'b0;
            result_o   <= '0;
            rd_o       <= '0;
        end else begin
            if (accept) begin
                op_q      <= md_op_e'(op_i);
                rs1_q     <= rs1_i;
                rs2_q     <= rs2_i;
                rd_q      <= rd_i;
                mul_cnt_q <= MCNT_W'(MUL_LATENCY - 1);
                step_q    <= DS_PREP;
            end else if ((state_q == ST_MUL) && (mul_cnt_q != '0)) begin
                mul_cnt_q <= mul_cnt_q - MCNT_W'(1);
            end

            if (div_start) begin
                step_q     <= DS_ITER;
                div_zero_q <= div_zero_d;
                div_ovf_q  <= div_ovf_d;
                q_neg_q    <= a_neg ^ b_neg;
                r_neg_q    <= a_neg;
            end

            if (finish) begin
                result_o <= result_d;
                rd_o     <= rd_q;
            end

            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (finish) begin
                valid_o <= 1'b1;
            end else if ((state_q == ST_DONE) && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_core_ex_muldiv_seq.sv
// Scoreboard bench for core_ex_muldiv_seq (XLEN=32, MUL_LATENCY=3, EARLY_OUT=1).
module tb_core_ex_muldiv_seq;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [2:0]      op_i = '0;
    logic [XLEN-1:0] rs1_i = '0;
    logic [XLEN-1:0] rs2_i = '0;
    logic [4:0]      rd_i = '0;
    logic            flush_i = 1'b0;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic            busy_o;

    core_ex_muldiv_seq #(
        .XLEN        (XLEN),
        .MUL_LATENCY (3),
        .EARLY_OUT   (1)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .rd_o     (rd_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        valid_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        rd_i    = rd;
    endtask

    // Issue one op, measure edges from accept to valid_o, compare against the scoreboard,
    // optionally hold off the consumer for `hold` cycles, then retire.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int lat,
                          input int hold);
        exp_t e;
        exp_t g;
        int   k;
        @(negedge clk_i);
        chk_eq("ready_before_issue", ready_o, 1);
        drive_req(op, a, b, rd);
        e.res = exp_res;
        e.rd  = rd;
        e.lat = lat;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        rs1_i   = $urandom;
        rs2_i   = $urandom;
        rd_i    = 5'($urandom);
        k = 0;
        do begin
            @(posedge clk_i);
            #1;
            k++;
        end while (!valid_o && k < 200);
        g = sb_q.pop_front();
        chk_eq("latency", k, g.lat);
        chk_eq("result", result_o, g.res);
        chk_eq("rd", rd_o, g.rd);
        chk_eq("ready_low_in_done", ready_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            chk_eq("hold_valid", valid_o, 1);
            chk_eq("hold_result", result_o, g.res);
            chk_eq("hold_rd", rd_o, g.rd);
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        chk_eq("valid_after_hs", valid_o, 0);
        chk_eq("ready_after_hs", ready_o, 1);
    endtask

    initial begin
        int seen;
        int k;
        logic [31:0] ra, rb;
        int sa, sb2;
        longint unsigned p;

        #3;
        chk_eq("rst_valid", valid_o, 0);
        chk_eq("rst_ready", ready_o, 1);
        chk_eq("rst_busy", busy_o, 0);
        chk_eq("rst_result", result_o, 0);
        chk_eq("rst_rd", rd_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Multiply forms
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 3, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 3, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 3, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 3, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFF, 3, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'h0000_0001, 3, 0);

        // Divide / remainder, including backpressure on one result
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34, 5);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 34, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 34, 0);

        // Special cases finish early
        run_op(3'd4, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 2, 0);
        run_op(3'd6, 32'd5, 32'd0, 5'd12, 32'd5, 2, 0);
        run_op(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 2, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 2, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 2, 0);
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 34, 0);

        // Random signed divide/remainder and unsigned high multiply against the reference model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i[0]) rb = rb >> 20;
            if (rb == 0) rb = 32'd3;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            sa  = ra;
            sb2 = rb;
            run_op(3'd4, ra, rb, 5'(17 + i), 32'(sa / sb2), 34, 0);
            run_op(3'd6, ra, rb, 5'(21 + i), 32'(sa % sb2), 34, 0);
            p = {32'd0, ra} * {32'd0, rb};
            run_op(3'd3, ra, rb, 5'(25 + i), p[63:32], 3, 0);
        end

        // Flush around divide iteration 10, with a competing request in the same cycle
        @(negedge clk_i);
        drive_req(3'd4, 32'd1000, 32'd3, 5'd4);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (11) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        drive_req(3'd0, 32'd9, 32'd9, 5'd30);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk_eq("flush_busy", busy_o, 0);
        chk_eq("flush_ready", ready_o, 1);
        chk_eq("flush_valid", valid_o, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen = 1;
        end
        chk_eq("flush_no_valid", seen, 0);
        run_op(3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 3, 0);

        // Flush wins over ready_i in DONE
        @(negedge clk_i);
        drive_req(3'd0, 32'd6, 32'd7, 5'd21);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        k = 0;
        do begin
            @(posedge clk_i);
            #1;
            k++;
        end while (!valid_o && k < 20);
        chk_eq("fdone_result", result_o, 42);
        flush_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        chk_eq("fdone_valid", valid_o, 0);
        chk_eq("fdone_ready", ready_o, 1);

        // Asynchronous reset in the middle of a multiply
        run_op(3'd0, 32'd11, 32'd11, 5'd17, 32'd121, 3, 0);
        @(negedge clk_i);
        drive_req(3'd0, 32'd5, 32'd6, 5'd18);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_eq("arst_valid", valid_o, 0);
        chk_eq("arst_busy", busy_o, 0);
        chk_eq("arst_ready", ready_o, 1);
        chk_eq("arst_result", result_o, 0);
        chk_eq("arst_rd", rd_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk_eq("arst_release_ready", ready_o, 1);
        run_op(3'd0, 32'd5, 32'd6, 5'd3, 32'd30, 3, 0);

        chk_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
